// File: rtl/pal_adapter_pkg.sv
// Shared definitions for the Dragon PAL adapter timing blocks.
// Holds the line-inserter state encoding and the default PAL stretch timing.
package pal_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_INSERT = 2'd2
    } ins_state_e;

    // 14.31818 MHz master clock: 912 cycles = 63.7 us line, 67 cycles = ~4.7 us sync
    localparam int LINE_CYCLES_PAL  = 912;
    localparam int HS_WIDTH_PAL     = 67;
    localparam int INSERT_LINES_PAL = 25;

endpackage

// File: rtl/pal_line_inserter_edge_sync.sv
// Two-flop synchroniser with a registered previous value and registered edge pulses.
// Pulses appear three clocks after the input edge; early is the first-stage level.
module edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic cp,
    input  logic mrb,
    input  logic d,
    output logic early,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchroniser chain plus edge detection against the previous synchronised level
    always_ff @(posedge cp or negedge mrb) begin
        if (!mrb) begin
            s1_r   <= RST_VAL;
            s2_r   <= RST_VAL;
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            s1_r   <= d;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            rise_r <= s2_r & ~prev_r;
            fall_r <= prev_r & ~s2_r;
        end
    end

    assign early = s1_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/pal_line_inserter.sv
// Stalls the VDG on each row-counter trigger and emits a block of synthetic
// blank lines with their own HSync, stretching the 60 Hz frame towards PAL.
module pal_line_inserter
    import pal_adapter_pkg::*;
#(
    parameter int LINE_CYCLES  = LINE_CYCLES_PAL,
    parameter int HS_WIDTH     = HS_WIDTH_PAL,
    parameter int INSERT_LINES = INSERT_LINES_PAL,
    parameter int CNT_W        = 10
) (
    input  logic       cp,
    input  logic       mrb,
    input  logic       hsb_in,
    input  logic       fsb_in,
    input  logic       trig,
    output logic       hsb_out,
    output logic       hold,
    output logic       blank,
    output logic [4:0] line_idx,
    output logic       abort
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(HS_WIDTH);
    localparam logic [4:0]       LINE_LAST = 5'(INSERT_LINES - 1);

    logic hs_early_s, hs_rise_s, hs_fall_s;
    logic fs_early_s, fs_rise_s, fs_fall_s;
    logic tr_early_s, tr_rise_s, tr_fall_s;
    logic unused_s;

    ins_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       line_r, line_s;
    logic             abort_s;
    logic             hsb_out_r, hold_r, blank_r, abort_r;

    edge_sync #(.RST_VAL(1'b1)) u_hs_sync (
        .cp(cp), .mrb(mrb), .d(hsb_in), .early(hs_early_s), .rise(hs_rise_s), .fall(hs_fall_s)
    );
    edge_sync #(.RST_VAL(1'b1)) u_fs_sync (
        .cp(cp), .mrb(mrb), .d(fsb_in), .early(fs_early_s), .rise(fs_rise_s), .fall(fs_fall_s)
    );
    edge_sync #(.RST_VAL(1'b0)) u_tr_sync (
        .cp(cp), .mrb(mrb), .d(trig), .early(tr_early_s), .rise(tr_rise_s), .fall(tr_fall_s)
    );

    assign unused_s = ^{hs_rise_s, fs_rise_s, fs_early_s, tr_fall_s, tr_early_s};

    // Next-state, line/cycle counting and abort decision
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        line_s  = line_r;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tr_rise_s) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // Frame sync beats a coincident HSync: the frame is already over
                if (fs_fall_s) begin
                    state_s = ST_IDLE;
                    abort_s = 1'b1;
                end else if (hs_fall_s) begin
                    state_s = ST_INSERT;
                    cnt_s   = CNT_ZERO;
                    line_s  = 5'd0;
                end else begin
                    state_s = ST_ALIGN;
                end
            end
            ST_INSERT: begin
                if (fs_fall_s) begin
                    state_s = ST_IDLE;
                    abort_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                    line_s  = 5'd0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (line_r == LINE_LAST) begin
                        state_s = ST_IDLE;
                        line_s  = 5'd0;
                    end else begin
                        line_s = line_r + 5'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                line_s  = 5'd0;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge cp or negedge mrb) begin
        if (!mrb) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            line_r    <= 5'd0;
            hsb_out_r <= 1'b1;
            hold_r    <= 1'b0;
            blank_r   <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            line_r  <= line_s;
            hold_r  <= (state_s == ST_INSERT);
            blank_r <= (state_s == ST_INSERT);
            abort_r <= abort_s;
            // Taking the first stage here gives a two-clock pass-through latency
            hsb_out_r <= (state_s == ST_INSERT) ? (cnt_s >= HS_END) : hs_early_s;
        end
    end

    assign hsb_out  = hsb_out_r;
    assign hold     = hold_r;
    assign blank    = blank_r;
    assign line_idx = line_r;
    assign abort    = abort_r;

endmodule

// File: tb/tb_pal_line_inserter.sv
// Bench for pal_line_inserter: a timing-level model predicts every output on
// every cycle, and directed scenarios pin latencies, lengths and pulse counts.
module tb_pal_line_inserter;

    localparam int LC = 912;
    localparam int HW = 67;
    localparam int NL = 25;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_INS  = 2;

    logic       cp = 1'b0;
    logic       mrb = 1'b0;
    logic       hsb_in = 1'b1;
    logic       fsb_in = 1'b1;
    logic       trig = 1'b0;
    logic       hsb_out, hold, blank, abort;
    logic [4:0] line_idx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state and expected outputs
    int   m_mode = M_IDLE;
    int   m_el = 0;
    logic [3:0] hh = 4'hF, fh = 4'hF, th = 4'h0;
    logic e_hsb = 1'b1, e_hold = 1'b0, e_blank = 1'b0, e_abort = 1'b0;
    int   e_line = 0;

    pal_line_inserter dut (
        .cp(cp), .mrb(mrb), .hsb_in(hsb_in), .fsb_in(fsb_in), .trig(trig),
        .hsb_out(hsb_out), .hold(hold), .blank(blank), .line_idx(line_idx), .abort(abort)
    );

    always #5 cp = ~cp;

    initial forever begin
        @(posedge cp);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: edges on the inputs take effect four clocks later; an insertion is
    // described only by the number of clocks since it began.
    initial forever begin : model
        bit ev_hs, ev_fs, ev_tr, ab;
        int el;
        @(posedge cp or negedge mrb);
        if (mrb !== 1'b1) begin
            m_mode = M_IDLE; m_el = 0;
            hh = 4'hF; fh = 4'hF; th = 4'h0;
            e_hsb = 1'b1; e_hold = 1'b0; e_blank = 1'b0; e_abort = 1'b0; e_line = 0;
        end else begin
            ev_hs = hh[3] & ~hh[2];
            ev_fs = fh[3] & ~fh[2];
            ev_tr = ~th[3] & th[2];
            ab = 1'b0;
            el = m_el + 1;
            case (m_mode)
                M_IDLE: if (ev_tr) m_mode = M_ARM;
                M_ARM: begin
                    if (ev_fs) begin m_mode = M_IDLE; ab = 1'b1; end
                    else if (ev_hs) begin m_mode = M_INS; el = 0; end
                end
                M_INS: begin
                    if (ev_fs) begin m_mode = M_IDLE; ab = 1'b1; end
                    else if (el >= LC * NL) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
            m_el    = el;
            e_abort = ab;
            e_hold  = (m_mode == M_INS);
            e_blank = (m_mode == M_INS);
            e_line  = (m_mode == M_INS) ? el / LC : 0;
            e_hsb   = (m_mode == M_INS) ? ((el % LC) >= HW) : hh[0];
            hh = {hh[2:0], hsb_in};
            fh = {fh[2:0], fsb_in};
            th = {th[2:0], trig};
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge cp);
        if (chk_en) begin
            check("hsb_out", {31'd0, hsb_out}, {31'd0, e_hsb});
            check("hold", {31'd0, hold}, {31'd0, e_hold});
            check("blank", {31'd0, blank}, {31'd0, e_blank});
            check("line_idx", {27'd0, line_idx}, e_line);
            check("abort", {31'd0, abort}, {31'd0, e_abort});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge cp);
    endtask

    task automatic pulse_trig();
        trig = 1'b1; tick(3); trig = 1'b0;
    endtask

    task automatic count_window(input int n, output int holds, output int aborts);
        holds = 0; aborts = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (hold === 1'b1) holds++;
            if (abort === 1'b1) aborts++;
        end
    endtask

    // trig, then hsb_in falls 200 clocks later; hold must rise 4 clocks after that edge
    task automatic start_insertion();
        int t0, w;
        pulse_trig();
        tick(200);
        hsb_in = 1'b0;
        t0 = cyc; w = 0;
        while (hold !== 1'b1 && w < 50) begin tick(1); w++; end
        check("hold_latency", cyc - t0, 4);
    endtask

    task automatic run_insertion(input int retrig_at, output int dur, output int lows, output int maxl);
        int t0, i;
        t0 = cyc; i = 0; lows = 0; maxl = 0;
        while (hold === 1'b1 && i < LC * NL + 200) begin
            if (blank === 1'b1 && hsb_out === 1'b0) lows++;
            if (int'(line_idx) > maxl) maxl = int'(line_idx);
            if (i == 100) hsb_in = 1'b1;
            if (i == retrig_at) trig = 1'b1;
            if (i == retrig_at + 3) trig = 1'b0;
            tick(1);
            i++;
        end
        dur = cyc - t0;
    endtask

    initial begin : stim
        int dur, lows, maxl, h, a, h2, a2, w;
        chk_en = 1'b1;
        // reset with inputs toggling
        for (int i = 0; i < 5; i++) begin
            tick(1);
            hsb_in = ~hsb_in; fsb_in = ~fsb_in; trig = ~trig;
        end
        check("rst_hold", {31'd0, hold}, 32'd0);
        check("rst_hsb", {31'd0, hsb_out}, 32'd1);
        hsb_in = 1'b1; fsb_in = 1'b1; trig = 1'b0;
        mrb = 1'b1;
        tick(10);

        // pass-through with assorted gaps; frame sync in IDLE is harmless
        for (int g = 1; g <= 8; g++) begin
            hsb_in = ~hsb_in;
            if (g == 4) fsb_in = 1'b0;
            if (g == 6) fsb_in = 1'b1;
            tick(g);
        end
        hsb_in = 1'b1;
        count_window(20, h, a);
        check("pass_no_hold", h, 0);

        // nominal insertion
        start_insertion();
        run_insertion(-10, dur, lows, maxl);
        check("ins_cycles", dur, LC * NL);
        check("ins_low_cycles", lows, 25 * 67);
        check("ins_max_line", maxl, 24);
        tick(20);

        // re-trigger mid-insertion is ignored, not queued
        start_insertion();
        run_insertion(5000, dur, lows, maxl);
        check("retrig_cycles", dur, 22800);
        check("retrig_low_cycles", lows, 1675);
        tick(10);
        hsb_in = 1'b0;
        count_window(100, h, a);
        hsb_in = 1'b1;
        check("no_queued_insert", h, 0);
        tick(10);

        // fresh trig starts a new insertion; frame sync during line 10 aborts it
        start_insertion();
        w = 0;
        while (line_idx !== 5'd10 && w < 12000) begin tick(1); w++; end
        check("reach_line10", {27'd0, line_idx}, 10);
        tick(100);
        fsb_in = 1'b0;
        count_window(8, h, a);
        check("ins_abort_pulses", a, 1);
        check("ins_abort_hold", {31'd0, hold}, 32'd0);
        check("ins_abort_line", {27'd0, line_idx}, 0);
        fsb_in = 1'b1; hsb_in = 1'b1;
        tick(20);

        // frame sync while waiting for HSync; later HSync must not start anything
        pulse_trig();
        tick(20);
        fsb_in = 1'b0;
        count_window(10, h, a);
        fsb_in = 1'b1;
        tick(10);
        hsb_in = 1'b0;
        count_window(30, h2, a2);
        hsb_in = 1'b1;
        check("align_abort_pulses", a + a2, 1);
        check("align_no_insert", h + h2, 0);
        tick(10);

        // HSync and frame sync on the same clock: frame sync wins
        pulse_trig();
        tick(20);
        hsb_in = 1'b0; fsb_in = 1'b0;
        count_window(30, h, a);
        hsb_in = 1'b1; fsb_in = 1'b1;
        check("tie_abort_pulses", a, 1);
        check("tie_no_insert", h, 0);
        tick(10);

        // reset mid-insertion drops hold without waiting for a clock
        start_insertion();
        tick(1000);
        @(posedge cp);
        #2 mrb = 1'b0;
        #1;
        check("async_rst_hold", {31'd0, hold}, 32'd0);
        check("async_rst_blank", {31'd0, blank}, 32'd0);
        tick(3);
        hsb_in = 1'b1;
        mrb = 1'b1;
        tick(20);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
